// File: rtl/ram_bank_pkg.sv
// rtl/ram_bank_pkg.sv - shared state encodings and sizing helpers for the ram_bank data RAM
package ram_bank_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_READY = 1'b1;

  localparam int RD_LAT_MAX = 4;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  // Out-of-range latencies are pulled back into 1..RD_LAT_MAX so the pipe depth stays sane.
  function automatic int clamp_lat(input int lat);
    if (lat < 1) return 1;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/ram_bank_rd_pipe.sv
// rtl/ram_bank_rd_pipe.sv - read-response delay line (valid/err/data), bypassed when STAGES is 0
module ram_bank_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int STAGES = 0
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);

  if (STAGES == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign out_err   = in_err;
    assign out_data  = in_data;
  end else begin : g_pipe
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] e_q;
    logic [DATA_W-1:0] d_q [STAGES];

    // Data registers only load behind a valid so the last stage holds the previous response.
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        e_q <= '0;
        for (int i = 0; i < STAGES; i++) d_q[i] <= '0;
      end else begin
        v_q[0] <= in_valid;
        e_q[0] <= in_err;
        if (in_valid) d_q[0] <= in_data;
        for (int i = 1; i < STAGES; i++) begin
          v_q[i] <= v_q[i-1];
          e_q[i] <= e_q[i-1];
          if (v_q[i-1]) d_q[i] <= d_q[i-1];
        end
      end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_err   = e_q[STAGES-1];
    assign out_data  = d_q[STAGES-1];
  end

endmodule

// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - single-port synchronous data RAM with request handshake, byte lanes,
// configurable read latency and optional zero-clear after reset
module ram_bank
  import ram_bank_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 9,
  parameter int DEPTH          = 256,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int               LANES       = lane_count(DATA_W);
  localparam int               CNT_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               PIPE_STAGES = clamp_lat(RD_LAT) - 1;
  localparam logic [ADDR_W:0]  DEPTH_EXT   = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CLR_LAST    = CNT_W'(DEPTH - 1);
  localparam state_t           ST_RESET    = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q;
  logic [CNT_W-1:0]  clr_cnt;
  logic              ready_q;

  logic              accept;
  logic              in_range;
  logic              wr_fire;
  logic              rd_fire;
  logic [CNT_W-1:0]  idx;

  logic              s1_valid;
  logic              s1_err;
  logic [DATA_W-1:0] s1_data;

  // The extra top bit keeps DEPTH == 2**ADDR_W representable, so a full-size array never errors.
  assign in_range = {1'b0, req_addr} < DEPTH_EXT;
  assign idx      = req_addr[CNT_W-1:0];
  assign accept   = req_valid & ready_q;
  assign wr_fire  = accept & req_wr & in_range;
  assign rd_fire  = accept & ~req_wr;

  assign req_ready = ready_q;
  assign init_done = ready_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == CLR_LAST) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: ready_q <= 1'b1;
        default:  state_q <= ST_RESET;
      endcase
    end
  end

  // Array has no reset; the clear sweep is what gives it known contents.
  always_ff @(posedge clock) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < LANES; i++) begin
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_fire;
      s1_err   <= rd_fire & ~in_range;
      if (rd_fire) s1_data <= in_range ? mem[idx] : '0;
    end
  end

  ram_bank_rd_pipe #(
    .DATA_W (DATA_W),
    .STAGES (PIPE_STAGES)
  ) u_rd_pipe (
    .clock     (clock),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_err    (s1_err),
    .in_data   (s1_data),
    .out_valid (rsp_valid),
    .out_err   (rsp_err),
    .out_data  (rsp_rdata)
  );

endmodule

// File: tb/tb_ram_bank.sv
// tb/tb_ram_bank.sv - two ram_bank instances (256 deep lat 1, 200 deep lat 4) driven in parallel
module tb_ram_bank;

  logic        clock     = 1'b0;
  logic        rst_n     = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wr    = 1'b0;
  logic [8:0]  req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be    = '0;

  logic        rdy   [2];
  logic        vld   [2];
  logic        err   [2];
  logic        idone [2];
  logic [31:0] rdata [2];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  ram_bank #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .RD_LAT(1), .CLEAR_ON_RESET(1)) dut_a (
    .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(vld[0]), .rsp_rdata(rdata[0]), .rsp_err(err[0]), .init_done(idone[0]));

  ram_bank #(.DATA_W(32), .ADDR_W(9), .DEPTH(200), .RD_LAT(4), .CLEAR_ON_RESET(1)) dut_b (
    .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(vld[1]), .rsp_rdata(rdata[1]), .rsp_err(err[1]), .init_done(idone[1]));

  function automatic int dep(input int k);
    return (k == 0) ? 256 : 200;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // Model: word array, a response calendar keyed by due edge, and cycles-since-reset.
  logic [31:0] mm [2][256];
  bit          sv [2][8];
  bit          se [2][8];
  logic [31:0] sd [2][8];
  bit          ev [2];
  bit          ee [2];
  bit          er [2];
  logic [31:0] ed [2];
  int          cnt [2];
  int          g = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; ev[k] = 0; ee[k] = 0; er[k] = 0; ed[k] = '0;
      for (int s = 0; s < 8; s++) sv[k][s] = 0;
      for (int a = 0; a < 256; a++) mm[k][a] = '0;
    end
  endtask

  initial begin
    int  a;
    int  slot;
    bit  inr;
    model_reset();
    forever begin
      @(posedge clock or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        g++;
        for (int k = 0; k < 2; k++) begin
          a   = int'(req_addr);
          inr = a < dep(k);
          if (req_valid && er[k]) begin
            if (req_wr) begin
              if (inr)
                for (int i = 0; i < 4; i++)
                  if (req_be[i]) mm[k][a][8*i +: 8] = req_wdata[8*i +: 8];
            end else begin
              slot = (g + lat(k) - 1) % 8;
              sv[k][slot] = 1;
              se[k][slot] = !inr;
              sd[k][slot] = inr ? mm[k][a] : 32'h0;
            end
          end
          if (cnt[k] < dep(k)) cnt[k]++;
          er[k] = cnt[k] >= dep(k);
          slot  = g % 8;
          ev[k] = sv[k][slot];
          ee[k] = sv[k][slot] && se[k][slot];
          if (sv[k][slot]) ed[k] = sd[k][slot];
          sv[k][slot] = 0;
        end
      end
    end
  end

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d actual=%h required=%h", nm, k, act, exp);
    end
  endtask

  task automatic cmp_inst(input int k, input logic r, input logic d, input logic v,
                          input logic e, input logic [31:0] rd);
    check("req_ready", k, 32'(r), 32'(er[k]));
    check("init_done", k, 32'(d), 32'(er[k]));
    check("rsp_valid", k, 32'(v), 32'(ev[k]));
    check("rsp_err",   k, 32'(e), 32'(ee[k]));
    check("rsp_rdata", k, rd, ed[k]);
  endtask

  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      cmp_inst(0, rdy[0], idone[0], vld[0], err[0], rdata[0]);
      cmp_inst(1, rdy[1], idone[1], vld[1], err[1], rdata[1]);
    end
  end

  task automatic issue(input bit wr, input int addr, input logic [31:0] wd, input logic [3:0] be);
    bit r;
    bit done;
    req_valid = 1; req_wr = wr; req_addr = 9'(addr); req_wdata = wd; req_be = be;
    done = 0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clock);
      r = rdy[0] & rdy[1];
      @(posedge clock); #1;
      done = r;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL accept_timeout addr=%0d actual=not_accepted required=accepted", addr);
    end
    req_valid = 0;
  endtask

  task automatic rd_expect(input string nm, input int addr, input logic [31:0] da, input bit ea,
                           input logic [31:0] db, input bit eb);
    bit got0, got1;
    logic [31:0] d0, d1;
    bit e0, e1;
    got0 = 0; got1 = 0; d0 = '0; d1 = '0; e0 = 0; e1 = 0;
    issue(0, addr, 32'h0, 4'h0);
    for (int n = 0; n < 10 && !(got0 && got1); n++) begin
      @(negedge clock);
      if (vld[0] && !got0) begin got0 = 1; d0 = rdata[0]; e0 = err[0]; end
      if (vld[1] && !got1) begin got1 = 1; d1 = rdata[1]; e1 = err[1]; end
    end
    if (!(got0 && got1)) begin
      total++; bad++;
      $display("FAIL %s_timeout actual=%0d%0d required=11", nm, got0, got1);
    end
    check({nm, "_data"}, 0, d0, da);
    check({nm, "_err"},  0, 32'(e0), 32'(ea));
    check({nm, "_data"}, 1, d1, db);
    check({nm, "_err"},  1, 32'(e1), 32'(eb));
    @(posedge clock); #1;
  endtask

  initial begin
    int t0, t1, nseen, leaks, rdy_hi;
    logic [31:0] seq_d [3];
    int          seq_t [3];

    repeat (2) @(posedge clock);
    #1 chk_en = 1;
    @(negedge clock);
    check("reset_ready", 0, 32'(rdy[0]), 32'h0);
    check("reset_rdata", 1, rdata[1], 32'h0);
    @(posedge clock); #1 rst_n = 1;

    t0 = -1; t1 = -1;
    for (int n = 0; n < 400 && t0 < 0; n++) begin
      @(negedge clock);
      if (idone[1] && t1 < 0) t1 = n;
      if (idone[0]) t0 = n;
    end
    check("init_cycles", 0, t0, 256);
    check("init_cycles", 1, t1, 200);
    @(posedge clock); #1;

    rd_expect("clear_0ff", 'h0FF, 32'h0, 0, 32'h0, 1);

    issue(1, 0, 32'h2245_0000, 4'hF);
    rd_expect("full_wr", 0, 32'h2245_0000, 0, 32'h2245_0000, 0);

    issue(1, 1, 32'h10F0_0010, 4'hF);
    issue(1, 1, 32'hAABB_CCDD, 4'b0101);
    rd_expect("byte_en", 1, 32'h10BB_00DD, 0, 32'h10BB_00DD, 0);
    issue(1, 1, 32'hFFFF_FFFF, 4'b0000);
    rd_expect("be_zero", 1, 32'h10BB_00DD, 0, 32'h10BB_00DD, 0);

    issue(0, 0, 32'h0, 4'h0);
    issue(0, 1, 32'h0, 4'h0);
    issue(0, 2, 32'h0, 4'h0);
    nseen = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clock);
      if (vld[1]) begin
        if (nseen < 3) begin seq_d[nseen] = rdata[1]; seq_t[nseen] = n; end
        nseen++;
      end
    end
    check("lat_count", 1, nseen, 3);
    if (nseen >= 3) begin
      check("lat_first", 1, seq_t[0], 1);
      check("lat_gap",   1, seq_t[1], seq_t[0] + 1);
      check("lat_gap",   1, seq_t[2], seq_t[0] + 2);
      check("lat_d0",    1, seq_d[0], 32'h2245_0000);
      check("lat_d1",    1, seq_d[1], 32'h10BB_00DD);
      check("lat_d2",    1, seq_d[2], 32'h0);
    end
    @(posedge clock); #1;

    issue(1, 300, 32'hDEAD_BEEF, 4'hF);
    issue(1, 220, 32'hCAFE_0220, 4'hF);
    issue(1, 199, 32'h0000_0199, 4'hF);
    rd_expect("oor_300", 300, 32'h0, 1, 32'h0, 1);
    rd_expect("alias_44", 44, 32'h0, 0, 32'h0, 0);
    rd_expect("edge_220", 220, 32'hCAFE_0220, 0, 32'h0, 1);
    rd_expect("last_199", 199, 32'h0000_0199, 0, 32'h0000_0199, 0);
    rd_expect("oor_511", 511, 32'h0, 1, 32'h0, 1);

    issue(0, 0, 32'h0, 4'h0);
    issue(0, 1, 32'h0, 4'h0);
    issue(0, 2, 32'h0, 4'h0);
    rst_n = 0;
    leaks = 0; rdy_hi = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clock);
      if (vld[0] || vld[1]) leaks++;
      if (rdy[0] || rdy[1]) rdy_hi++;
    end
    check("rst_no_rsp", 1, leaks, 0);
    check("rst_ready", 1, rdy_hi, 0);
    @(posedge clock); #1 rst_n = 1;
    rd_expect("reclear_0", 0, 32'h0, 0, 32'h0, 0);

    repeat (6) @(posedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
